// File: rtl/mux_tree_pipelined.sv
// mux_tree_pipelined
//   N_IN:1 multiplexer built as a binary tree of 2:1 levels. Every tree level
//   ends in its own pipeline register with a valid/ready handshake, so beats
//   stream through at one per cycle. Level k consumes select bit k-1 (LSB
//   first) and forwards the full select of the beat as a tag, so out_sel
//   always names the lane on out_data.
//   The ready chain is purely combinational and runs backwards from
//   out_ready. An empty stage therefore accepts even while the stage after
//   it is stalled. This lets bubbles collapse, and in_ready only drops when
//   every stage is full.
module mux_tree_pipelined #(
   parameter int WIDTH = 8,
   parameter int N_IN  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [N_IN*WIDTH-1:0]     in_data,
   input  logic [$clog2(N_IN)-1:0]   in_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(N_IN)-1:0]   out_sel
);

   localparam int LEVELS = $clog2(N_IN);
   localparam int SEL_W  = LEVELS;

   // A tree of 2:1 levels only closes cleanly on a power-of-two lane count.
   if ((N_IN < 2) || ((N_IN & (N_IN - 1)) != 0)) begin : g_bad_n_in
      $error("mux_tree_pipelined: N_IN must be a power of 2 and at least 2");
   end

   // One pipeline stage per tree level. Stage k holds N_IN>>k lanes.
   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int LANES_IN  = N_IN >> (k - 1);
      localparam int LANES_OUT = N_IN >> k;

      logic                          valid_prev_s;
      logic [LANES_IN*WIDTH-1:0]     lane_prev_s;
      logic [SEL_W-1:0]              sel_prev_s;
      logic                          ready_next_s;
      logic                          ready_s;
      logic [LANES_OUT*WIDTH-1:0]    mux_s;
      logic                          valid_r;
      logic [LANES_OUT*WIDTH-1:0]    lane_r;
      logic [SEL_W-1:0]              sel_r;

      // Predecessor: stage 0 is the input port itself.
      if (k == 1) begin : g_src_port
         assign valid_prev_s = in_valid;
         assign lane_prev_s  = in_data;
         assign sel_prev_s   = in_sel;
      end else begin : g_src_stage
         assign valid_prev_s = g_lvl[k-1].valid_r;
         assign lane_prev_s  = g_lvl[k-1].lane_r;
         assign sel_prev_s   = g_lvl[k-1].sel_r;
      end

      // Successor readiness: the last stage is drained by out_ready.
      if (k == LEVELS) begin : g_sink_port
         assign ready_next_s = out_ready;
      end else begin : g_sink_stage
         assign ready_next_s = g_lvl[k+1].ready_s;
      end

      // A stage can load when it is empty or when its content leaves this cycle.
      assign ready_s = !valid_r || ready_next_s;

      // Halve the lane count using this level's select bit from the incoming beat.
      always_comb begin
         mux_s = {(LANES_OUT*WIDTH){1'b0}};
         for (int j = 0; j < LANES_OUT; j++) begin
            if (sel_prev_s[k-1]) begin
               mux_s[j*WIDTH +: WIDTH] = lane_prev_s[(2*j+1)*WIDTH +: WIDTH];
            end else begin
               mux_s[j*WIDTH +: WIDTH] = lane_prev_s[(2*j)*WIDTH +: WIDTH];
            end
         end
      end

      // Stage register: load valid, lanes and sel on ready. Otherwise hold everything.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_r <= 1'b0;
            lane_r  <= {(LANES_OUT*WIDTH){1'b0}};
            sel_r   <= {SEL_W{1'b0}};
         end else if (ready_s) begin
            valid_r <= valid_prev_s;
            lane_r  <= mux_s;
            sel_r   <= sel_prev_s;
         end
      end
   end

   assign in_ready  = g_lvl[1].ready_s;
   assign out_valid = g_lvl[LEVELS].valid_r;
   assign out_data  = g_lvl[LEVELS].lane_r;
   assign out_sel   = g_lvl[LEVELS].sel_r;

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// tb_mux_tree_pipelined
//   Two instances share one clock and one reset: a 4-lane/8-bit tree and an
//   8-lane/16-bit tree. Each instance has a scoreboard queue. A beat's expected
//   lane and tag are pushed when the input handshake is seen, and popped when
//   the output handshake is seen. Every scenario task also checks timing and
//   handshake behaviour inline.
module tb_mux_tree_pipelined;

   logic         clk = 1'b0;
   logic         rst;

   logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [31:0]  a_in_data;
   logic [1:0]   a_in_sel, a_out_sel;
   logic [7:0]   a_out_data;

   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [127:0] b_in_data;
   logic [2:0]   b_in_sel, b_out_sel;
   logic [15:0]  b_out_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  sel;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];
   beat_t ea;
   beat_t eb;

   always #5 clk = ~clk;

   mux_tree_pipelined #(.WIDTH(8), .N_IN(4)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .in_sel    (a_in_sel),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .out_sel   (a_out_sel)
   );

   mux_tree_pipelined #(.WIDTH(16), .N_IN(8)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .in_sel    (b_in_sel),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_sel   (b_out_sel)
   );

   // Distinct 16-bit lane values for the wide instance. pat selects the pattern set.
   function automatic logic [15:0] lane_b(int pat, int j);
      return 16'((j + 1) * 4096 + j * 17 + pat * 256);
   endfunction

   // Scoreboard for instance A. A reset cycle discards all in-flight beats.
   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
      end else begin
         if (a_out_valid && a_out_ready) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL sb_a_extra: got beat data=%h sel=%0d, required no beat", a_out_data, a_out_sel);
            end else begin
               ea = qa.pop_front();
               if (a_out_data !== ea.data[7:0] || a_out_sel !== ea.sel[1:0]) begin
                  errors++;
                  $display("FAIL sb_a_beat: got data=%h sel=%0d, required data=%h sel=%0d",
                           a_out_data, a_out_sel, ea.data[7:0], ea.sel[1:0]);
               end
            end
         end
         if (a_in_valid && a_in_ready) begin
            qa.push_back('{data: {8'h00, a_in_data[int'(a_in_sel)*8 +: 8]}, sel: {1'b0, a_in_sel}});
         end
      end
   end

   // Scoreboard for instance B.
   always @(negedge clk) begin
      if (rst) begin
         qb.delete();
      end else begin
         if (b_out_valid && b_out_ready) begin
            checks++;
            if (qb.size() == 0) begin
               errors++;
               $display("FAIL sb_b_extra: got beat data=%h sel=%0d, required no beat", b_out_data, b_out_sel);
            end else begin
               eb = qb.pop_front();
               if (b_out_data !== eb.data || b_out_sel !== eb.sel) begin
                  errors++;
                  $display("FAIL sb_b_beat: got data=%h sel=%0d, required data=%h sel=%0d",
                           b_out_data, b_out_sel, eb.data, eb.sel);
               end
            end
         end
         if (b_in_valid && b_in_ready) begin
            qb.push_back('{data: b_in_data[int'(b_in_sel)*16 +: 16], sel: b_in_sel});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         tick();
         a_in_valid  = 1'b0;
         b_in_valid  = 1'b0;
         a_out_ready = 1'b1;
         b_out_ready = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00 || a_out_sel !== 2'd0) begin
         errors++;
         $display("FAIL reset_a: got v=%b r=%b d=%h s=%0d, required v=0 r=1 d=00 s=0",
                  a_out_valid, a_in_ready, a_out_data, a_out_sel);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_data !== 16'h0000 || b_out_sel !== 3'd0) begin
         errors++;
         $display("FAIL reset_b: got v=%b r=%b d=%h s=%0d, required v=0 r=1 d=0000 s=0",
                  b_out_valid, b_in_ready, b_out_data, b_out_sel);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      tick();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'h44332211;
      a_in_sel    = 2'd2;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_in_ready: got %b, required 1", a_in_ready);
      end
      tick();
      a_in_valid = 1'b0;
      a_in_sel   = 2'd0;
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got out_valid=%b after 1 cycle, required 0", a_out_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== 8'h33 || a_out_sel !== 2'd2) begin
         errors++;
         $display("FAIL single_out: got v=%b d=%h s=%0d, required v=1 d=33 s=2",
                  a_out_valid, a_out_data, a_out_sel);
      end
      idle(3);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d;
      a_in_data = 32'h44332211;
      for (int i = 0; i < 6; i++) begin
         tick();
         a_out_ready = 1'b1;
         a_in_valid  = (i < 4);
         a_in_sel    = 2'(i);
         @(negedge clk);
         if (i < 4) begin
            checks++;
            if (a_in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_in_ready[%0d]: got %b, required 1", i, a_in_ready);
            end
         end
         if (i >= 2) begin
            exp_d = 8'(8'h11 * (i - 1));
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d || a_out_sel !== 2'(i - 2)) begin
               errors++;
               $display("FAIL b2b_out[%0d]: got v=%b d=%h s=%0d, required v=1 d=%h s=%0d",
                        i, a_out_valid, a_out_data, a_out_sel, exp_d, i - 2);
            end
         end
      end
      idle(3);
   endtask

   task automatic test_stall();
      logic [1:0] sel_tab [3] = '{2'd3, 2'd1, 2'd0};
      int idx = 0;
      a_in_data = 32'h44332211;
      for (int c = 0; c < 8; c++) begin
         tick();
         a_out_ready = (c >= 4);
         a_in_valid  = (idx < 3);
         a_in_sel    = (idx < 3) ? sel_tab[idx] : 2'd0;
         @(negedge clk);
         if (c < 2 || c == 4) begin
            checks++;
            if (a_in_ready !== 1'b1) begin
               errors++;
               $display("FAIL stall_accept[%0d]: got in_ready=%b, required 1", c, a_in_ready);
            end
         end
         if (c == 2 || c == 3) begin
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 8'h44 || a_out_sel !== 2'd3) begin
               errors++;
               $display("FAIL stall_hold[%0d]: got r=%b v=%b d=%h s=%0d, required r=0 v=1 d=44 s=3",
                        c, a_in_ready, a_out_valid, a_out_data, a_out_sel);
            end
         end
         if (c == 5 || c == 6) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== ((c == 5) ? 8'h22 : 8'h11)) begin
               errors++;
               $display("FAIL stall_drain[%0d]: got v=%b d=%h, required v=1 d=%h",
                        c, a_out_valid, a_out_data, (c == 5) ? 8'h22 : 8'h11);
            end
         end
         if (c == 7) begin
            checks++;
            if (a_out_valid !== 1'b0) begin
               errors++;
               $display("FAIL stall_empty: got out_valid=%b, required 0", a_out_valid);
            end
         end
         if (a_in_valid && a_in_ready) idx++;
      end
      idle(2);
   endtask

   task automatic test_bubble();
      a_in_data = 32'h44332211;
      tick();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_sel    = 2'd1;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bubble_first: got in_ready=%b, required 1", a_in_ready);
      end
      tick();
      a_in_valid = 1'b0;
      tick();
      a_in_valid = 1'b1;
      a_in_sel   = 2'd2;
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bubble_collapse: got v=%b r=%b, required v=1 r=1", a_out_valid, a_in_ready);
      end
      tick();
      a_in_sel = 2'd3;
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || a_out_data !== 8'h22) begin
         errors++;
         $display("FAIL bubble_full: got r=%b d=%h, required r=0 d=22", a_in_ready, a_out_data);
      end
      idle(4);
   endtask

   task automatic test_reset_flush();
      a_in_data = 32'hDDCCBBAA;
      tick();
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_sel    = 2'd0;
      tick();
      a_in_sel = 2'd1;
      tick();
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      rst         = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00 || a_out_sel !== 2'd0) begin
         errors++;
         $display("FAIL flush_state: got v=%b r=%b d=%h s=%0d, required v=0 r=1 d=00 s=0",
                  a_out_valid, a_in_ready, a_out_data, a_out_sel);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         checks++;
         if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ghost[%0d]: got out_valid=%b data=%h, required 0", c, a_out_valid, a_out_data);
         end
      end
   endtask

   task automatic test_wide();
      int s;
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < 8; j++) b_in_data[j*16 +: 16] = lane_b(p, j);
         for (int i = 0; i < 11; i++) begin
            tick();
            b_out_ready = 1'b1;
            b_in_valid  = (i < 8);
            b_in_sel    = (p == 0) ? 3'(i) : 3'(7 - i);
            @(negedge clk);
            if (i < 8) begin
               checks++;
               if (b_in_ready !== 1'b1) begin
                  errors++;
                  $display("FAIL wide_in_ready[%0d/%0d]: got %b, required 1", p, i, b_in_ready);
               end
            end
            if (i >= 3) begin
               s = (p == 0) ? (i - 3) : (10 - i);
               checks++;
               if (b_out_valid !== 1'b1 || b_out_data !== lane_b(p, s) || b_out_sel !== 3'(s)) begin
                  errors++;
                  $display("FAIL wide_out[%0d/%0d]: got v=%b d=%h s=%0d, required v=1 d=%h s=%0d",
                           p, i, b_out_valid, b_out_data, b_out_sel, lane_b(p, s), s);
               end
            end
         end
         idle(2);
      end
   endtask

   // Hard stop in case the run ever wedges.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      rst         = 1'b1;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      a_in_data   = 32'h0;
      a_in_sel    = 2'd0;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      b_in_data   = 128'h0;
      b_in_sel    = 3'd0;

      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_bubble();
      test_reset_flush();
      test_wide();
      idle(4);

      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d/%0d beats outstanding, required 0/0", qa.size(), qb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
